// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//
// Staged reset controller. All NUM_STAGES reset outputs start asserted; after
// HOLD_CYCLES they are released one at a time in index order. Each released
// stage must report ready before the next stage is released after GAP_CYCLES.
// A stage that stays silent for TIMEOUT cycles is logged in a sticky error
// and the sequence continues as if it had reported ready. A software request
// restarts the whole sequence and is acknowledged when it completes.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_rst          asynchronous active-high reset
//   i_sw_rst_req   software reset request, level, sampled every cycle
//   o_sw_rst_ack   1-cycle pulse when a software-requested sequence completes
//   i_stage_ready  per-stage "out of reset" feedback
//   o_stage_rst    per-stage reset, active-high, registered
//   o_busy         sequence in progress
//   o_done         all stages released
//   o_timeout_err  sticky: some stage missed TIMEOUT
//   o_err_stage    index of the first stage that timed out
//   o_dbg_state    current FSM state encoding (debug visibility)
//
// Request/acknowledge semantics: i_sw_rst_req is a level sampled on every
// posedge. In DONE it restarts the sequence on the next edge. While busy it
// sets a single pending flag (repeats collapse); the pending restart is taken
// after a one-cycle DONE visit. o_sw_rst_ack pulses in the first DONE cycle of
// every sequence that was started by software, never for the power-on one.
// ---------------------------------------------------------------------------
module rst_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sw_rst_req,
  output logic                  o_sw_rst_ack,
  input  logic [NUM_STAGES-1:0] i_stage_ready,
  output logic [NUM_STAGES-1:0] o_stage_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout_err,
  output logic [3:0]            o_err_stage,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_RELEASE  = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int MAXV_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXV    = (MAXV_HG > TIMEOUT) ? MAXV_HG : TIMEOUT;
  localparam int CW      = $clog2(MAXV + 1);
  localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TMO_VAL   = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_timeout_err;
  logic [3:0]            r_err_stage;
  logic                  r_pending;
  logic                  r_sw_seq;
  logic                  r_ack;

  logic w_ready;
  logic w_last;
  logic w_tmo;
  logic w_accept;
  logic w_restart;

  always_comb begin
    w_ready   = i_stage_ready[r_idx];
    w_last    = (r_idx == LAST_IDX);
    // Ready wins over a timeout landing in the same cycle.
    w_tmo     = !w_ready && (r_count == TMO_VAL);
    w_accept  = w_ready || (r_count == TMO_VAL);
    w_restart = (r_state == ST_DONE) && (i_sw_rst_req || r_pending);
  end

  // Next-state logic. HOLD releases stage 0 itself on its final edge so the
  // first low cycle of stage 0 is HOLD_CYCLES+1; later stages spend one cycle
  // in RELEASE after their gap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HOLD: begin
        if (r_count == HOLD_LAST) w_next = ST_WAIT_RDY;
      end
      ST_RELEASE: begin
        w_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (w_accept) begin
          if (w_last)               w_next = ST_DONE;
          else if (GAP_CYCLES == 0) w_next = ST_RELEASE;
          else                      w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_count == GAP_LAST) w_next = ST_RELEASE;
      end
      ST_DONE: begin
        if (w_restart) w_next = ST_HOLD;
      end
      default: w_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_HOLD;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count       <= '0;
      r_idx         <= '0;
      r_stage_rst   <= '1;
      r_timeout_err <= 1'b0;
      r_err_stage   <= 4'd0;
      r_pending     <= 1'b0;
      r_sw_seq      <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_ack <= (r_state != ST_DONE) && (w_next == ST_DONE) && r_sw_seq;

      // One shared counter, cleared on every state change and frozen in the
      // states that do not time anything, so it can never wrap.
      if (w_next != r_state)
        r_count <= '0;
      else if (r_state == ST_HOLD || r_state == ST_WAIT_RDY || r_state == ST_GAP)
        r_count <= r_count + CW'(1);

      if (w_restart)
        r_pending <= 1'b0;
      else if (i_sw_rst_req && r_state != ST_DONE)
        r_pending <= 1'b1;

      case (r_state)
        ST_HOLD: begin
          if (w_next == ST_WAIT_RDY) r_stage_rst[0] <= 1'b0;
        end
        ST_RELEASE: begin
          r_stage_rst[r_idx] <= 1'b0;
        end
        ST_WAIT_RDY: begin
          if (w_tmo && !r_timeout_err) begin
            r_timeout_err <= 1'b1;
            r_err_stage   <= 4'(r_idx);
          end
          if (w_next == ST_RELEASE) r_idx <= r_idx + IW'(1);
        end
        ST_GAP: begin
          if (w_next == ST_RELEASE) r_idx <= r_idx + IW'(1);
        end
        ST_DONE: begin
          if (w_restart) begin
            r_stage_rst   <= '1;
            r_idx         <= '0;
            r_timeout_err <= 1'b0;
            r_err_stage   <= 4'd0;
            r_sw_seq      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_stage_rst   = r_stage_rst;
  assign o_busy        = (r_state != ST_DONE);
  assign o_done        = (r_state == ST_DONE);
  assign o_sw_rst_ack  = r_ack;
  assign o_timeout_err = r_timeout_err;
  assign o_err_stage   = r_err_stage;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//
// Reference model: for each sequence the release cycle of every stage, the
// DONE cycle and the timeout cycle are computed arithmetically from the
// per-stage ready latencies, then every cycle of the DUT output bundle is
// compared against those numbers. A responder raises stage_ready[i] a chosen
// number of cycles after stage i is observed leaving reset.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

  localparam int NS    = 3;
  localparam int HOLD  = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 64;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [NS-1:0] rdy;
  logic          ack;
  logic [NS-1:0] srst;
  logic          busy;
  logic          done;
  logic          terr;
  logic [3:0]    estg;
  logic [2:0]    dbg;

  int n_vec = 0;
  int n_err = 0;
  int d[NS];
  int lowcnt[NS];
  bit tied;

  rst_sequencer #(
    .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_rst_req(req), .o_sw_rst_ack(ack),
    .i_stage_ready(rdy), .o_stage_rst(srst), .o_busy(busy), .o_done(done),
    .o_timeout_err(terr), .o_err_stage(estg), .o_dbg_state(dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One full reset sequence: cycle 1 is the first cycle after rst drops or
  // after the restart edge. Ends either with a restart (pending request or a
  // request pulsed in the last DONE cycle) or in DONE.
  task automatic test_sequence(input bit sw, input int rq1, input int rq2,
                               input int tail, input bit req_in_done,
                               input string name);
    int r[NS];
    int dc;
    int tj;
    int acc;
    int last_c;
    bit pend;
    logic [NS+7:0] exp_v;
    logic [NS+7:0] obs_v;
    logic [NS-1:0] exp_rst;
    logic          exp_terr;
    logic [3:0]    exp_es;
    tj   = -1;
    dc   = 0;
    r[0] = HOLD + 1;
    for (int i = 0; i < NS; i++) begin
      acc = tied ? 0 : ((d[i] > TMO) ? TMO : d[i]);
      if (!tied && d[i] > TMO && tj < 0) tj = i;
      if (i < NS - 1) r[i+1] = r[i] + acc + 1 + GAP + 1;
      else            dc     = r[i] + acc + 1;
    end
    pend   = (rq1 > 0 && rq1 < dc) || (rq2 > 0 && rq2 < dc);
    last_c = pend ? dc : dc + tail;
    for (int i = 0; i < NS; i++) lowcnt[i] = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) exp_rst[i] = (c < r[i]);
      exp_terr = (tj >= 0) && (c >= r[tj] + TMO + 1);
      exp_es   = exp_terr ? 4'(tj) : 4'd0;
      exp_v = {exp_rst, (c < dc), (c >= dc), (sw && c == dc), exp_terr, exp_es};
      obs_v = {srst, busy, done, ack, terr, estg};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d {rst,busy,done,ack,terr,es}: got %b want %b",
                 name, c, obs_v, exp_v);
      end
      // Responder: ready d[i] cycles after stage i is seen out of reset.
      for (int i = 0; i < NS; i++) begin
        if (srst[i] == 1'b0) lowcnt[i]++;
        rdy[i] = tied ? 1'b1 : (lowcnt[i] >= d[i] + 1);
      end
      if (c == rq1 || c == rq2 || (req_in_done && !pend && c == last_c)) begin
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    rdy = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({srst, busy, done, ack, terr, estg} !== {3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", {srst, busy, done, ack, terr, estg},
               {3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    end
    release_rst();
  endtask

  task automatic test_tied_ready();
    tied = 1'b1;
    for (int i = 0; i < NS; i++) d[i] = 0;
    rdy = '1;
    test_sequence(1'b0, 0, 0, 3, 1'b1, "tied_ready");
  endtask

  task automatic test_sw_restart();
    tied = 1'b1;
    test_sequence(1'b1, 0, 0, 2, 1'b1, "sw_restart");
  endtask

  task automatic test_back_to_back();
    tied = 1'b0;
    d[0] = 2; d[1] = 12; d[2] = 1;
    // Stage 1 is released on cycle 17; both pulses land in its WAIT_RDY.
    test_sequence(1'b1, 19, 22, 0, 1'b0, "b2b_pending");
    d[0] = 0; d[1] = 3; d[2] = 5;
    test_sequence(1'b1, 0, 0, 4, 1'b1, "b2b_replay");
  endtask

  task automatic test_timeout();
    tied = 1'b0;
    d[0] = 0; d[1] = NEVER; d[2] = 0;
    test_sequence(1'b1, 0, 0, 2, 1'b1, "timeout");
  endtask

  task automatic test_ready_at_timeout();
    tied = 1'b0;
    d[0] = 1; d[1] = 3; d[2] = TMO;
    test_sequence(1'b1, 0, 0, 2, 1'b1, "ready_at_timeout");
  endtask

  task automatic test_random();
    int rq;
    tied = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NS; i++) d[i] = $urandom_range(0, TMO + 8);
      rq = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : 0;
      test_sequence(1'b1, rq, 0, 2, (k < 5), "random");
    end
  endtask

  task automatic test_async_reset();
    // Assert from DONE: takes effect without waiting for a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({srst, busy, done} !== 5'b11110) begin
      n_err++;
      $display("FAIL async_rst_from_done: got %b want %b", {srst, busy, done}, 5'b11110);
    end
    tied = 1'b0;
    d[0] = 0; d[1] = NEVER; d[2] = 0;
    rdy = '0;
    release_rst();
    for (int i = 0; i < NS; i++) lowcnt[i] = 0;
    // Stage 1 released on cycle 15; its timeout shows from cycle 80.
    for (int c = 1; c <= HOLD + 1 + 6 + TMO + 1; c++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (srst[i] == 1'b0) lowcnt[i]++;
        rdy[i] = (lowcnt[i] >= d[i] + 1);
      end
    end
    n_vec++;
    if ({srst, terr, estg} !== {3'b100, 1'b1, 4'd1}) begin
      n_err++;
      $display("FAIL pre_async_rst: got %b want %b", {srst, terr, estg}, {3'b100, 1'b1, 4'd1});
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({srst, busy, done, terr, estg} !== {3'b111, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL async_rst_mid: got %b want %b", {srst, busy, done, terr, estg},
               {3'b111, 1'b1, 1'b0, 1'b0, 4'd0});
    end
  endtask

  initial begin
    tied = 1'b0;
    test_reset();
    test_tied_ready();
    test_sw_restart();
    test_back_to_back();
    test_timeout();
    test_ready_at_timeout();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
